// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing for the sequential sign-magnitude to BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int MAG_W   = 5;
  localparam int DIGIT_W = 4;
  localparam int N_ITER  = 5;
  localparam int SHIFT_W = 2 * DIGIT_W + MAG_W;
  localparam int CNT_W   = 3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: any digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] q_o
);

  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Converts a 6-bit sign-magnitude value to two BCD digits plus sign,
// one double-dabble iteration per clock.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter bit NEG_ZERO_CLEAR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAG_W:0]     bin_in,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units,
  output logic               neg
);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [SHIFT_W-1:0]   shift_d;
  logic                 sign_q;
  logic                 nz_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DIGIT_W-1:0]   tens_q;
  logic [DIGIT_W-1:0]   units_q;
  logic                 neg_q;
  logic [DIGIT_W-1:0]   tensAdj;
  logic [DIGIT_W-1:0]   unitsAdj;
  logic                 neg_d;

  bcd_add3 u_addTens (
    .d_i (shift_q[SHIFT_W-1 -: DIGIT_W]),
    .q_o (tensAdj)
  );

  bcd_add3 u_addUnits (
    .d_i (shift_q[MAG_W+DIGIT_W-1 -: DIGIT_W]),
    .q_o (unitsAdj)
  );

  assign shift_d = {tensAdj, unitsAdj, shift_q[MAG_W-1:0]} << 1;

  // A magnitude of zero keeps the sign only when negative zero is to be shown.
  assign neg_d = sign_q & (nz_q | ~NEG_ZERO_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      sign_q  <= 1'b0;
      nz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tens_q  <= '0;
      units_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CONV;
            cnt_q   <= '0;
            shift_q <= {{(SHIFT_W-MAG_W){1'b0}}, bin_in[MAG_W-1:0]};
            sign_q  <= bin_in[MAG_W];
            nz_q    <= |bin_in[MAG_W-1:0];
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == CNT_W'(N_ITER - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            tens_q  <= shift_d[SHIFT_W-1 -: DIGIT_W];
            units_q <= shift_d[MAG_W+DIGIT_W-1 -: DIGIT_W];
            neg_q   <= neg_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign tens  = tens_q;
  assign units = units_q;
  assign neg   = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq, run with both settings of negative-zero handling.
module tb_bin2bcd_seq;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    logic       neg0;
    logic       neg1;
  } result_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] bin_in;
  logic       busy, done, neg;
  logic [3:0] tens, units;
  logic       busy1, done1, neg1;
  logic [3:0] tens1, units1;

  result_t scoreboard[$];
  int      checkCount = 0;
  int      passCount  = 0;
  int      phase      = 0;
  logic    expBusy    = 1'b0;
  logic    expDone    = 1'b0;
  logic [3:0] heldTens  = '0;
  logic [3:0] heldUnits = '0;
  logic       heldNeg0  = 1'b0;
  logic       heldNeg1  = 1'b0;

  bin2bcd_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .tens   (tens),
    .units  (units),
    .neg    (neg)
  );

  bin2bcd_seq #(.NEG_ZERO_CLEAR(1'b0)) dutKeep (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy1),
    .done   (done1),
    .tens   (tens1),
    .units  (units1),
    .neg    (neg1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One start pulse, then enough cycles for the conversion to finish and return to IDLE.
  task automatic applyStimulus(input logic [5:0] value);
    bin_in = value;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (7) tick();
  endtask

  // Cycle-level reference: capture pushes the expected result, DONE is five edges later.
  always @(posedge clk) begin
    result_t r;
    if (rst) begin
      phase     = 0;
      scoreboard.delete();
      heldTens  = '0;
      heldUnits = '0;
      heldNeg0  = 1'b0;
      heldNeg1  = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        r.tens  = 4'(int'(bin_in[4:0]) / 10);
        r.units = 4'(int'(bin_in[4:0]) % 10);
        r.neg0  = bin_in[5] && (bin_in[4:0] != 5'd0);
        r.neg1  = bin_in[5];
        scoreboard.push_back(r);
        phase = 1;
      end
    end else if (phase == 6) begin
      phase = 0;
    end else begin
      phase++;
    end
    expBusy = (phase != 0);
    expDone = (phase == 6);
  end

  always @(negedge clk) begin
    result_t r;
    if (expDone) begin
      if (scoreboard.size() == 0) begin
        checkOutput("sbUnderflow", 8'd0, 8'd1);
      end else begin
        r = scoreboard.pop_front();
        heldTens  = r.tens;
        heldUnits = r.units;
        heldNeg0  = r.neg0;
        heldNeg1  = r.neg1;
      end
    end
    checkOutput("busy",   8'(busy),   8'(expBusy));
    checkOutput("done",   8'(done),   8'(expDone));
    checkOutput("tens",   8'(tens),   8'(heldTens));
    checkOutput("units",  8'(units),  8'(heldUnits));
    checkOutput("neg",    8'(neg),    8'(heldNeg0));
    checkOutput("doneK",  8'(done1),  8'(expDone));
    checkOutput("tensK",  8'(tens1),  8'(heldTens));
    checkOutput("unitsK", 8'(units1), 8'(heldUnits));
    checkOutput("negK",   8'(neg1),   8'(heldNeg1));
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    applyStimulus(6'b010111);
    checkOutput("r23Tens", 8'(tens), 8'd2);
    checkOutput("r23Units", 8'(units), 8'd3);
    applyStimulus(6'b111111);
    checkOutput("n31Neg", 8'(neg), 8'd1);
    applyStimulus(6'b100000);
    checkOutput("negZero", 8'(neg), 8'd0);
    checkOutput("negZeroK", 8'(neg1), 8'd1);

    // Start held high: second capture lands seven cycles after the first.
    bin_in = 6'b000101;
    start  = 1'b1;
    repeat (2) tick();
    bin_in = 6'b001010;
    repeat (8) tick();
    start = 1'b0;
    repeat (8) tick();
    checkOutput("heldTens", 8'(tens), 8'd1);
    checkOutput("heldUnits", 8'(units), 8'd0);

    // Reset in the third CONV cycle aborts the conversion.
    bin_in = 6'b011110;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkOutput("abortBusy", 8'(busy), 8'd0);
    checkOutput("abortTens", 8'(tens), 8'd0);
    rst = 1'b0;
    tick();
    applyStimulus(6'b001101);

    // Reset wins over a simultaneous start.
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 6'b011001;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rstStartBusy", 8'(busy), 8'd0);
    repeat (3) tick();
    checkOutput("rstStartIdle", 8'(busy), 8'd0);

    for (int code = 0; code < 64; code++) begin
      applyStimulus(6'(code));
    end

    checkOutput("sbDrain", 8'(scoreboard.size()), 8'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
